chunk_loader: RTL

//  Sits between uart_receive and l3_cache. Deframes the chunk stream sent by the server plugin

---
 rtl/chunk_loader.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/chunk_loader.sv
// Deframes the server chunk stream into one l3_cache write per block with (x,y,z) addressing.
// Optional run-length payload decoding is enabled by defining CHUNK_LOADER_RLE_EN.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | hunting for SYNC_BYTE; other bytes are discarded
// LOAD    | waiting for next payload byte (run count byte when RLE is on)
// PAIR_HI | RLE only: waiting for the block byte of a (count,block) pair
// WRITE   | write request held on the cache port until accepted
// CHECK   | waiting for the checksum byte that closes the frame
module chunk_loader #(
   parameter int          LENGTH         = 64,
   parameter int          WIDTH          = 64,
   parameter int          HEIGHT         = 16,
   parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
   parameter int          TIMEOUT_CYCLES = 100000
) (
   input  logic                       clk_in,
   input  logic                       rst_in,
   input  logic [7:0]                 rx_data_in,
   input  logic                       rx_valid_in,
   input  logic                       wr_ready_in,
   output logic                       wr_valid_out,
   output logic [$clog2(LENGTH)-1:0]  wr_x_out,
   output logic [$clog2(WIDTH)-1:0]   wr_y_out,
   output logic [$clog2(HEIGHT)-1:0]  wr_z_out,
   output logic [7:0]                 wr_data_out,
   output logic                       loaded_out,
   output logic                       cksum_err_out,
   output logic                       frame_err_out
);

   localparam int XW = $clog2(LENGTH);
   localparam int YW = $clog2(WIDTH);
   localparam int ZW = $clog2(HEIGHT);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

`ifdef CHUNK_LOADER_RLE_EN
   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_PAIR_HI, S_WRITE, S_CHECK
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_WRITE, S_CHECK
   } state_t;
`endif

   state_t          state_q, state_d;
   logic [XW-1:0]   x_q, x_d;
   logic [YW-1:0]   y_q, y_d;
   logic [ZW-1:0]   z_q, z_d;
   logic [7:0]      acc_q, acc_d;
   logic [7:0]      data_q, data_d;
   logic [TW-1:0]   tmr_q, tmr_d;
   logic            valid_q, valid_d;
   logic            loaded_q, loaded_d;
   logic            cksum_err_q, cksum_err_d;
   logic            frame_err_q, frame_err_d;
   logic            timeout;
   logic            last_blk;
`ifdef CHUNK_LOADER_RLE_EN
   logic [7:0]      run_q, run_d;
`endif

   // Idle-gap timer counts down from TIMEOUT_CYCLES; terminal count is the last idle cycle allowed.
   assign timeout  = (state_q != S_IDLE) && !rx_valid_in && (tmr_q == TW'(1));
   assign last_blk = (x_q == XW'(LENGTH - 1)) && (y_q == YW'(WIDTH - 1)) &&
                     (z_q == ZW'(HEIGHT - 1));

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q     <= S_IDLE;
         x_q         <= '0;
         y_q         <= '0;
         z_q         <= '0;
         acc_q       <= '0;
         data_q      <= '0;
         tmr_q       <= TW'(TIMEOUT_CYCLES);
         valid_q     <= 1'b0;
         loaded_q    <= 1'b0;
         cksum_err_q <= 1'b0;
         frame_err_q <= 1'b0;
`ifdef CHUNK_LOADER_RLE_EN
         run_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         z_q         <= z_d;
         acc_q       <= acc_d;
         data_q      <= data_d;
         tmr_q       <= tmr_d;
         valid_q     <= valid_d;
         loaded_q    <= loaded_d;
         cksum_err_q <= cksum_err_d;
         frame_err_q <= frame_err_d;
`ifdef CHUNK_LOADER_RLE_EN
         run_q       <= run_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      z_d         = z_q;
      acc_d       = acc_q;
      data_d      = data_q;
      loaded_d    = loaded_q;
      cksum_err_d = 1'b0;
      frame_err_d = 1'b0;
`ifdef CHUNK_LOADER_RLE_EN
      run_d       = run_q;
`endif
      if (state_q == S_IDLE || rx_valid_in) begin
         tmr_d = TW'(TIMEOUT_CYCLES);
      end else if (tmr_q != '0) begin
         tmr_d = tmr_q - TW'(1);
      end else begin
         tmr_d = tmr_q;
      end

      case (state_q)
         S_IDLE: begin
            if (rx_valid_in && rx_data_in == SYNC_BYTE) begin
               x_d      = '0;
               y_d      = '0;
               z_d      = '0;
               acc_d    = '0;
               loaded_d = 1'b0;
               state_d  = S_LOAD;
            end
         end
         S_LOAD: begin
            if (timeout) begin
               frame_err_d = 1'b1;
               state_d     = S_IDLE;
            end else if (rx_valid_in) begin
               acc_d = acc_q ^ rx_data_in;
`ifdef CHUNK_LOADER_RLE_EN
               if (rx_data_in == 8'd0) begin
                  frame_err_d = 1'b1;
                  state_d     = S_IDLE;
               end else begin
                  run_d   = rx_data_in;
                  state_d = S_PAIR_HI;
               end
`else
               data_d  = rx_data_in;
               state_d = S_WRITE;
`endif
            end
         end
`ifdef CHUNK_LOADER_RLE_EN
         S_PAIR_HI: begin
            if (timeout) begin
               frame_err_d = 1'b1;
               state_d     = S_IDLE;
            end else if (rx_valid_in) begin
               acc_d   = acc_q ^ rx_data_in;
               data_d  = rx_data_in;
               state_d = S_WRITE;
            end
         end
`endif
         S_WRITE: begin
            // A byte arriving while a write is still pending has nowhere to go.
            if (rx_valid_in) begin
               frame_err_d = 1'b1;
               state_d     = S_IDLE;
            end else if (timeout) begin
               frame_err_d = 1'b1;
               state_d     = S_IDLE;
            end else if (wr_ready_in) begin
               if (last_blk) begin
`ifdef CHUNK_LOADER_RLE_EN
                  if (run_q != 8'd1) begin
                     frame_err_d = 1'b1;
                     state_d     = S_IDLE;
                  end else begin
                     state_d = S_CHECK;
                  end
`else
                  state_d = S_CHECK;
`endif
               end else begin
                  if (x_q == XW'(LENGTH - 1)) begin
                     x_d = '0;
                     if (y_q == YW'(WIDTH - 1)) begin
                        y_d = '0;
                        z_d = z_q + ZW'(1);
                     end else begin
                        y_d = y_q + YW'(1);
                     end
                  end else begin
                     x_d = x_q + XW'(1);
                  end
`ifdef CHUNK_LOADER_RLE_EN
                  if (run_q == 8'd1) begin
                     state_d = S_LOAD;
                  end else begin
                     run_d = run_q - 8'd1;
                  end
`else
                  state_d = S_LOAD;
`endif
               end
            end
         end
         S_CHECK: begin
            if (timeout) begin
               frame_err_d = 1'b1;
               state_d     = S_IDLE;
            end else if (rx_valid_in) begin
               if (rx_data_in == acc_q) begin
                  loaded_d = 1'b1;
               end else begin
                  cksum_err_d = 1'b1;
               end
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      valid_d = (state_d == S_WRITE);
   end

   assign wr_valid_out  = valid_q;
   assign wr_x_out      = x_q;
   assign wr_y_out      = y_q;
   assign wr_z_out      = z_q;
   assign wr_data_out   = data_q;
   assign loaded_out    = loaded_q;
   assign cksum_err_out = cksum_err_q;
   assign frame_err_out = frame_err_q;

endmodule
